// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with single outstanding request and IF/ID register
// Ports:
//   clk, rst (async, active-low)             clock and reset
//   PC_write, IF_ID_write                    hazard-unit stall controls (accept = both high)
//   redirect_valid, redirect_pc              control-flow redirect from EX, highest priority
//   im_req, im_addr                          one-cycle fetch request to instruction memory
//   im_rvalid, im_rdata                      fetch data return
//   IF_ID_pc, IF_ID_inst, IF_ID_valid        IF/ID pipeline register
//   fetch_busy                               fetch FSM not idle
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_write,
    input  logic        IF_ID_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid,
    output logic        fetch_busy
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;
    state_t state, state_nx;
    logic [31:0] pc, hold_buf, load_word;
    logic accept, load, capture;
    assign accept     = PC_write & IF_ID_write;
    assign im_addr    = pc;
    assign fetch_busy = state != IDLE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    always_comb begin
        state_nx  = state;
        im_req    = 1'b0;
        load      = 1'b0;
        capture   = 1'b0;
        load_word = hold_buf;
        case (state)
            IDLE: if (!redirect_valid) begin
                // gate with rst so no request escapes while reset is held
                im_req   = rst;
                state_nx = WAIT;
            end
            WAIT: if (redirect_valid) begin
                state_nx = im_rvalid ? IDLE : DROP;
            end else if (im_rvalid) begin
                load      = accept;
                capture   = !accept;
                load_word = im_rdata;
                state_nx  = accept ? IDLE : HOLD;
            end
            HOLD: if (redirect_valid) begin
                state_nx = IDLE;
            end else if (accept) begin
                load     = 1'b1;
                state_nx = IDLE;
            end
            DROP: state_nx = im_rvalid ? IDLE : DROP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            hold_buf    <= '0;
            IF_ID_pc    <= '0;
            IF_ID_inst  <= NOP_INST;
            IF_ID_valid <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc          <= redirect_pc & ~32'd3;
                IF_ID_inst  <= NOP_INST;
                IF_ID_valid <= 1'b0;
            end else if (load) begin
                IF_ID_pc    <= pc;
                IF_ID_inst  <= load_word;
                IF_ID_valid <= 1'b1;
                pc          <= pc + 32'd4;
            end else if (IF_ID_write) begin
                // nothing to deliver: inject a bubble
                IF_ID_inst  <= NOP_INST;
                IF_ID_valid <= 1'b0;
            end
            if (capture) hold_buf <= im_rdata;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized and directed checks of if_fetch_unit against a transaction-level model
module tb_if_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0, rst = 1'b1;
    logic PC_write = 1'b0, IF_ID_write = 1'b0, redirect_valid = 1'b0, im_rvalid = 1'b0;
    logic [31:0] redirect_pc = '0, im_rdata = '0;
    logic im_req, IF_ID_valid, fetch_busy;
    logic [31:0] im_addr, IF_ID_pc, IF_ID_inst;
    always #5 clk = ~clk;
    if_fetch_unit #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .im_req(im_req), .im_addr(im_addr), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid),
        .fetch_busy(fetch_busy)
    );
    int n_chk = 0, n_err = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    // model: fetch outstanding / poisoned, word waiting in buffer, architectural pc and IF/ID
    logic [31:0] m_pc, m_ipc, m_inst, m_buf;
    logic m_valid, m_out, m_drop, m_held;
    bit mem_busy;
    int mem_cnt;
    logic [31:0] mem_addr;
    bit pw, iw, rd, stale;
    logic [31:0] rpc;
    int lat = 1;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction
    task automatic model_reset();
        m_pc = RPC; m_ipc = '0; m_inst = NOP; m_buf = '0;
        m_valid = 1'b0; m_out = 1'b0; m_drop = 1'b0; m_held = 1'b0;
        mem_busy = 1'b0;
    endtask
    task automatic cycle();
        bit req, acc, ld;
        logic [31:0] w;
        @(negedge clk);
        im_rvalid = 1'b0;
        im_rdata  = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                im_rvalid = 1'b1;
                im_rdata  = mem_word(mem_addr);
                mem_busy  = 1'b0;
            end
        end else if (stale) im_rvalid = 1'b1;
        PC_write = pw; IF_ID_write = iw; redirect_valid = rd; redirect_pc = rpc;
        req = !m_out && !m_held && !rd;
        #1;
        chk("im_req", 32'(im_req), 32'(req));
        if (req) begin
            chk("im_addr", im_addr, m_pc);
            mem_busy = 1'b1; mem_addr = m_pc; mem_cnt = lat;
        end
        acc = pw && iw; ld = 1'b0; w = '0;
        if (rd) begin
            m_pc = rpc & ~32'd3; m_held = 1'b0; m_valid = 1'b0; m_inst = NOP;
            if (m_out) begin
                if (im_rvalid) begin m_out = 1'b0; m_drop = 1'b0; end
                else m_drop = 1'b1;
            end
        end else begin
            if (m_held) begin
                if (acc) begin ld = 1'b1; w = m_buf; m_held = 1'b0; end
            end else if (m_out && im_rvalid) begin
                m_out = 1'b0;
                if (m_drop) m_drop = 1'b0;
                else if (acc) begin ld = 1'b1; w = im_rdata; end
                else begin m_held = 1'b1; m_buf = im_rdata; end
            end
            if (ld) begin
                m_ipc = m_pc; m_inst = w; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end else if (iw) begin
                m_valid = 1'b0; m_inst = NOP;
            end
            if (req) begin m_out = 1'b1; m_drop = 1'b0; end
        end
        @(posedge clk);
        #1;
        chk("pc", im_addr, m_pc);
        chk("IF_ID_pc", IF_ID_pc, m_ipc);
        chk("IF_ID_inst", IF_ID_inst, m_inst);
        chk("IF_ID_valid", 32'(IF_ID_valid), 32'(m_valid));
        chk("fetch_busy", 32'(fetch_busy), 32'(m_out || m_held));
    endtask
    task automatic run(input bit p, input bit i, input bit r, input logic [31:0] a,
                       input int l, input bit s, input int n);
        pw = p; iw = i; rd = r; rpc = a; lat = l; stale = s;
        for (int k = 0; k < n; k++) cycle();
    endtask
    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_im_req", 32'(im_req), 32'd0);
        chk("rst_pc", im_addr, RPC);
        chk("rst_IF_ID_pc", IF_ID_pc, 32'd0);
        chk("rst_IF_ID_inst", IF_ID_inst, NOP);
        chk("rst_IF_ID_valid", 32'(IF_ID_valid), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b1;
    endtask
    initial begin
        logic [31:0] r;
        model_reset();
        do_reset();
        run(1, 1, 0, '0, 1, 0, 8);
        chk("stream_pc", IF_ID_pc, 32'h0000_000C);
        run(1, 1, 0, '0, 1, 0, 1);
        run(0, 0, 0, '0, 1, 0, 3);
        chk("hold_busy", 32'(fetch_busy), 32'd1);
        chk("hold_pc", IF_ID_pc, 32'h0000_000C);
        run(1, 1, 0, '0, 1, 0, 1);
        chk("hold_load", IF_ID_inst, mem_word(32'h0000_0010));
        chk("hold_next", im_addr, 32'h0000_0014);
        run(1, 1, 0, '0, 3, 0, 1);
        run(1, 1, 1, 32'h0000_0103, 1, 0, 1);
        chk("drop_valid", 32'(IF_ID_valid), 32'd0);
        run(1, 1, 0, '0, 1, 0, 3);
        chk("redir_addr", im_addr, 32'h0000_0100);
        run(1, 1, 0, '0, 1, 0, 1);
        run(0, 0, 1, 32'h0000_0200, 1, 0, 1);
        chk("same_cycle_inst", IF_ID_inst, NOP);
        chk("same_cycle_busy", 32'(fetch_busy), 32'd0);
        run(1, 1, 0, '0, 1, 0, 2);
        run(1, 1, 1, 32'hFFFF_FFFC, 1, 0, 1);
        run(1, 1, 0, '0, 1, 0, 2);
        chk("wrap_pc", IF_ID_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", im_addr, 32'h0000_0000);
        run(1, 1, 0, '0, 2, 0, 1);
        do_reset();
        run(1, 1, 0, '0, 1, 1, 1);
        run(1, 1, 0, '0, 1, 0, 1);
        chk("stale_ignored", IF_ID_inst, mem_word(RPC));
        for (int k = 0; k < 3000; k++) begin
            r = $urandom;
            pw = $urandom_range(0, 3) != 0;
            iw = $urandom_range(0, 3) != 0;
            rd = $urandom_range(0, 9) == 0;
            rpc = ($urandom_range(0, 3) == 0) ? {28'hFFF_FFFF, r[3:0]} : $urandom;
            lat = $urandom_range(1, 3);
            stale = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
